ram_copier: RTL and testbench
=============================

# ram_copier

Sequential bus initiator driving the single-port memory interface (`addr`/`in`/`ld`/`out`) of the RAM hierarchy from the requester side. On a start pulse it either copies a block of words from a source address to a destination address, or fills a block with a constant. Two cycles per word for copy (read, then write), one cycle per word for fill. It sits between the CPU/control logic and the RAM's single port, muxed in ahead of the CPU.

## Interface
- `DATA_W`, 16, word width
- `ADDR_W`, 15, address width; all address arithmetic is modulo 2^ADDR_W
- `LEN_W`, 15, width of the word count
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `start` input 1: one-cycle request; sampled only in IDLE
- `mode` input 1: 0 = copy, 1 = fill; sampled with `start`
- `src` input ADDR_W: copy source base; sampled with `start`
- `dst` input ADDR_W: destination base; sampled with `start`
- `len` input LEN_W: word count; sampled with `start`
- `fill_val` input DATA_W: fill word; sampled with `start`
- `mem_out` input DATA_W: RAM read data; combinational function of `mem_addr`
- `mem_addr` output ADDR_W: RAM address
- `mem_in` output DATA_W: RAM write data
- `mem_ld` output 1: RAM write enable; the RAM writes on the `clk` edge while high
- `busy` output 1: high while a transfer is in progress
- `done` output 1: one-cycle completion pulse

## Operation
- States: IDLE, READ, WRITE, FILL.
- All request inputs are latched on the accepting edge and held in internal registers: base addresses, remaining count, word index `i`, fill word and a `DATA_W` holding register.
- IDLE:
  - `start`=1 and `len`=0: stay IDLE and pulse `done` next cycle. No memory access.
  - `start`=1, `mode`=0, `len`>0: go to READ with `i`=0.
  - `start`=1, `mode`=1, `len`>0: go to FILL with `i`=0.
- READ: `mem_addr`=`src`+`i`, `mem_ld`=0. Capture `mem_out` into the holding register at the edge, then go to WRITE.
- WRITE: `mem_addr`=`dst`+`i`, `mem_in`=holding register, `mem_ld`=1.
  - If `i`=`len`-1: go to IDLE and pulse `done`.
  - Otherwise increment `i` and go to READ.
- FILL: `mem_addr`=`dst`+`i`, `mem_in`=`fill_val`, `mem_ld`=1.
  - If `i`=`len`-1: go to IDLE and pulse `done`.
  - Otherwise increment `i` and stay in FILL.
- Copies always run in ascending address order.
  - For overlapping regions with `src` < `dst` < `src`+`len`, the result is the defined ascending-order result: source words are overwritten before being read. Bench checks against that model.
- Address sums wrap modulo 2^ADDR_W, e.g. `dst`=0x7FFF, `i`=1 gives `mem_addr`=0x0000.
- `start` while `busy` is ignored. It is not queued.
- `mem_addr`, `mem_in` and `mem_ld` are driven from registered state only, with no combinational path from `start`.

## Timing
- Reset (async assert): state=IDLE; `busy`=0, `done`=0, `mem_ld`=0, `mem_addr`=0, `mem_in`=0 immediately, without waiting for a clock edge.
  - A transfer interrupted by reset is abandoned. Memory keeps the words already written; no further write occurs.
- In IDLE: `mem_addr`=0, `mem_in`=0, `mem_ld`=0.
- `busy`=1 exactly while state is READ, WRITE or FILL. It rises the cycle after the accepting edge.
- Busy duration: copy = 2·`len` cycles; fill = `len` cycles.
- `done` is high for exactly one cycle, the cycle after the last write (busy already 0).
  - For `len`=0, `done` is high the cycle after the accepting edge.
- A new `start` is accepted in the same cycle `done` is high, since state is IDLE.
- Maximum `len` = 2^LEN_W−1. There is no internal overflow of `i`.

## Test plan
- Copy: preload RAM[0x0010..0x0013]=0x1111,0x2222,0x3333,0x4444; start `mode`=0, `src`=0x0010, `dst`=0x0100, `len`=4.
  - Required: busy high for 8 cycles, `done` pulses once.
  - Required: RAM[0x0100..0x0103] match the source; source words are unchanged.
- Fill: `mode`=1, `dst`=0x2000, `len`=3, `fill_val`=0xBEEF.
  - Required: `mem_ld` high for 3 consecutive cycles at addresses 0x2000, 0x2001, 0x2002; RAM holds 0xBEEF there; `done` next cycle.
- Wrap and zero length: fill with `dst`=0x7FFE, `len`=3, `fill_val`=0x00AA.
  - Required: writes to 0x7FFE, 0x7FFF, 0x0000.
  - Then `len`=0: no `mem_ld`, busy stays 0, `done` pulses the cycle after start.
- Overlap: RAM[0..3]=1,2,3,4; copy `src`=0, `dst`=1, `len`=3.
  - Required: RAM[0..3]=1,1,1,1 (ascending-order model).
- Start while busy and back-to-back: pulse `start` mid-copy with different arguments → ignored, memory matches the first request only.
  - Then assert `start` in the `done` cycle → accepted, busy rises the next cycle.
- Reset mid-copy: assert `rst` during the WRITE of word 2 of 4, between edges.
  - Required: `mem_ld`, `busy` and `done` drop to 0 immediately.
  - Required: only words 0–1 written; words 2–3 unchanged; IDLE after release.

Source files
------------

// File: rtl/ram_copier_if.sv
// ram_copier_if
//   Bundles the request handshake (start/mode/src/dst/len/fill_val -> busy/done)
//   and the single-port RAM bus (mem_addr/mem_in/mem_ld <- mem_out) seen by the
//   block copier.
//
//   master : the copier itself (consumes requests, drives the RAM port)
//   slave  : the environment (issues requests, provides the RAM)
interface ram_copier_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 15
);
    // Request side
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] fill_val;
    logic              busy;
    logic              done;

    // RAM port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_in;
    logic              mem_ld;
    logic [DATA_W-1:0] mem_out;

    modport master (
        input  start, mode, src, dst, len, fill_val, mem_out,
        output busy, done, mem_addr, mem_in, mem_ld
    );

    modport slave (
        output start, mode, src, dst, len, fill_val, mem_out,
        input  busy, done, mem_addr, mem_in, mem_ld
    );
endinterface

// File: rtl/ram_copier.sv
// ram_copier
//   Sequential bus initiator for the RAM's single port. On a start pulse it
//   either copies len words from src to dst (read cycle + write cycle per word,
//   ascending addresses) or fills len words at dst with fill_val (one write
//   cycle per word). All address arithmetic wraps modulo 2^ADDR_W.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset; abandons any transfer in flight
//   bus  : ram_copier_if.master
//            start/mode/src/dst/len/fill_val sampled only in IDLE
//            busy  high while READ/WRITE/FILL
//            done  one-cycle pulse after the last write (or after a len=0 start)
//            mem_addr/mem_in/mem_ld registered RAM port, mem_out read data
module ram_copier #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 15
) (
    input  logic          clk,
    input  logic          rst,
    ram_copier_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_FILL  = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_i;
    logic [LEN_W-1:0]  r_last;     // index of the final word, len-1
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] r_hold;     // word captured during READ

    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_in;
    logic              r_mem_ld;
    logic              r_busy;
    logic              r_done;

    logic              w_last;
    logic [LEN_W-1:0]  w_i_next;

    // base + index, wrapping at 2^ADDR_W
    function automatic logic [ADDR_W-1:0] addr_at(
        input logic [ADDR_W-1:0] base,
        input logic [LEN_W-1:0]  idx
    );
        return base + ADDR_W'(idx);
    endfunction

    assign w_last   = (r_i == r_last);
    // len is at most 2^LEN_W-1 so i never needs to reach 2^LEN_W-1+1
    assign w_i_next = r_i + LEN_W'(1);

    // Outputs are registered: each transition loads the values the next
    // state presents on the RAM port, so nothing combinational reaches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_i        <= '0;
            r_last     <= '0;
            r_fill     <= '0;
            r_hold     <= '0;
            r_mem_addr <= '0;
            r_mem_in   <= '0;
            r_mem_ld   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_mem_addr <= '0;
                    r_mem_in   <= '0;
                    r_mem_ld   <= 1'b0;
                    r_busy     <= 1'b0;
                    if (bus.start) begin
                        r_src  <= bus.src;
                        r_dst  <= bus.dst;
                        r_fill <= bus.fill_val;
                        r_i    <= '0;
                        r_last <= bus.len - LEN_W'(1);
                        if (bus.len == '0) begin
                            // Nothing to move: acknowledge immediately.
                            r_done <= 1'b1;
                        end else if (!bus.mode) begin
                            r_state    <= S_READ;
                            r_mem_addr <= bus.src;
                            r_busy     <= 1'b1;
                        end else begin
                            r_state    <= S_FILL;
                            r_mem_addr <= bus.dst;
                            r_mem_in   <= bus.fill_val;
                            r_mem_ld   <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    r_hold     <= bus.mem_out;
                    r_state    <= S_WRITE;
                    r_mem_addr <= addr_at(r_dst, r_i);
                    r_mem_in   <= bus.mem_out;
                    r_mem_ld   <= 1'b1;
                end

                S_WRITE: begin
                    if (w_last) begin
                        r_state    <= S_IDLE;
                        r_mem_addr <= '0;
                        r_mem_in   <= '0;
                        r_mem_ld   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_i        <= w_i_next;
                        r_state    <= S_READ;
                        r_mem_addr <= addr_at(r_src, w_i_next);
                        r_mem_in   <= '0;
                        r_mem_ld   <= 1'b0;
                    end
                end

                S_FILL: begin
                    if (w_last) begin
                        r_state    <= S_IDLE;
                        r_mem_addr <= '0;
                        r_mem_in   <= '0;
                        r_mem_ld   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_i        <= w_i_next;
                        r_mem_addr <= addr_at(r_dst, w_i_next);
                        r_mem_in   <= r_fill;
                        r_mem_ld   <= 1'b1;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_mem_ld <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_in   = r_mem_in;
    assign bus.mem_ld   = r_mem_ld;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_ram_copier.sv
// tb_ram_copier
//   Directed bench for ram_copier with a behavioural single-port RAM.
module tb_ram_copier;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;
    localparam int LEN_W  = 15;

    logic clk;
    logic rst;

    ram_copier_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    ram_copier #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural RAM: async read, write on clk while mem_ld. A preload port
    // lets the bench seed contents while the copier is idle.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;

    assign bus.mem_out = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_ld)
            mem[bus.mem_addr] <= bus.mem_in;
        else if (pre_we)
            mem[pre_addr] <= pre_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    logic [ADDR_W-1:0] ld_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
    endtask

    // Drive a one-cycle request; returns in the first cycle after acceptance.
    task automatic request(input logic m, input logic [ADDR_W-1:0] s,
                           input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] n,
                           input logic [DATA_W-1:0] f);
        bus.mode     = m;
        bus.src      = s;
        bus.dst      = d;
        bus.len      = n;
        bus.fill_val = f;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    // Count busy and write cycles until done is seen; stops in the done cycle.
    task automatic watch(input int limit, output int nbusy, output int nld);
        bit seen;
        nbusy = 0;
        nld   = 0;
        seen  = 1'b0;
        ld_q.delete();
        for (int c = 0; c < limit && !seen; c++) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) nbusy++;
                if (bus.mem_ld) begin
                    nld++;
                    ld_q.push_back(bus.mem_addr);
                end
                step();
            end
        end
        if (!seen) chk("done_timeout", {31'd0, bus.done}, 32'd1);
    endtask

    int nb;
    int nl;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        pre_we      = 1'b0;
        pre_addr    = '0;
        pre_data    = '0;
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.src      = '0;
        bus.dst      = '0;
        bus.len      = '0;
        bus.fill_val = '0;

        step();
        step();
        chk("rst_busy",   {31'd0, bus.busy},   32'd0);
        chk("rst_done",   {31'd0, bus.done},   32'd0);
        chk("rst_ld",     {31'd0, bus.mem_ld}, 32'd0);
        chk("rst_addr",   32'(bus.mem_addr),   32'h0);
        chk("rst_in",     32'(bus.mem_in),     32'h0);
        rst = 1'b0;
        step();

        // ---- Copy 4 words 0x0010 -> 0x0100
        preload(15'h0010, 16'h1111);
        preload(15'h0011, 16'h2222);
        preload(15'h0012, 16'h3333);
        preload(15'h0013, 16'h4444);
        for (int k = 0; k < 4; k++) preload(15'h0100 + 15'(k), 16'h0000);
        request(1'b0, 15'h0010, 15'h0100, 15'd4, 16'h0000);
        watch(100, nb, nl);
        chk("copy_busy_cycles", 32'(nb), 32'd8);
        chk("copy_writes",      32'(nl), 32'd4);
        chk("copy_done",        {31'd0, bus.done}, 32'd1);
        chk("copy_busy_at_done",{31'd0, bus.busy}, 32'd0);
        step();
        chk("copy_done_once",   {31'd0, bus.done}, 32'd0);
        chk("copy_d0", 32'(mem[15'h0100]), 32'h1111);
        chk("copy_d1", 32'(mem[15'h0101]), 32'h2222);
        chk("copy_d2", 32'(mem[15'h0102]), 32'h3333);
        chk("copy_d3", 32'(mem[15'h0103]), 32'h4444);
        chk("copy_s0", 32'(mem[15'h0010]), 32'h1111);
        chk("copy_s3", 32'(mem[15'h0013]), 32'h4444);

        // ---- Fill 3 words at 0x2000
        request(1'b1, 15'h0000, 15'h2000, 15'd3, 16'hBEEF);
        watch(100, nb, nl);
        chk("fill_busy_cycles", 32'(nb), 32'd3);
        chk("fill_writes",      32'(nl), 32'd3);
        if (nl == 3) begin
            chk("fill_a0", 32'(ld_q[0]), 32'h2000);
            chk("fill_a1", 32'(ld_q[1]), 32'h2001);
            chk("fill_a2", 32'(ld_q[2]), 32'h2002);
        end
        chk("fill_done", {31'd0, bus.done}, 32'd1);
        step();
        chk("fill_m0", 32'(mem[15'h2000]), 32'hBEEF);
        chk("fill_m1", 32'(mem[15'h2001]), 32'hBEEF);
        chk("fill_m2", 32'(mem[15'h2002]), 32'hBEEF);

        // ---- Fill across the address wrap
        request(1'b1, 15'h0000, 15'h7FFE, 15'd3, 16'h00AA);
        watch(100, nb, nl);
        chk("wrap_writes", 32'(nl), 32'd3);
        if (nl == 3) begin
            chk("wrap_a0", 32'(ld_q[0]), 32'h7FFE);
            chk("wrap_a1", 32'(ld_q[1]), 32'h7FFF);
            chk("wrap_a2", 32'(ld_q[2]), 32'h0000);
        end
        step();
        chk("wrap_m2", 32'(mem[15'h0000]), 32'h00AA);

        // ---- Zero length
        request(1'b1, 15'h0000, 15'h1234, 15'd0, 16'h5A5A);
        chk("zero_done", {31'd0, bus.done},   32'd1);
        chk("zero_busy", {31'd0, bus.busy},   32'd0);
        chk("zero_ld",   {31'd0, bus.mem_ld}, 32'd0);
        step();
        chk("zero_done_once", {31'd0, bus.done}, 32'd0);
        chk("zero_busy2",     {31'd0, bus.busy}, 32'd0);

        // ---- Overlapping copy src=0 dst=1 len=3
        preload(15'h0000, 16'd1);
        preload(15'h0001, 16'd2);
        preload(15'h0002, 16'd3);
        preload(15'h0003, 16'd4);
        request(1'b0, 15'h0000, 15'h0001, 15'd3, 16'h0000);
        watch(100, nb, nl);
        chk("ovl_busy_cycles", 32'(nb), 32'd6);
        step();
        chk("ovl_m0", 32'(mem[15'h0000]), 32'd1);
        chk("ovl_m1", 32'(mem[15'h0001]), 32'd1);
        chk("ovl_m2", 32'(mem[15'h0002]), 32'd1);
        chk("ovl_m3", 32'(mem[15'h0003]), 32'd1);

        // ---- Start while busy is ignored; start in the done cycle is taken
        preload(15'h0300, 16'hA5A5);
        preload(15'h0301, 16'h5A5A);
        preload(15'h0400, 16'h0000);
        preload(15'h0401, 16'h0000);
        preload(15'h0500, 16'h5555);
        preload(15'h0501, 16'h5555);
        preload(15'h0600, 16'h0000);
        request(1'b0, 15'h0300, 15'h0400, 15'd2, 16'h0000);
        step();
        request(1'b1, 15'h0000, 15'h0500, 15'd2, 16'hDEAD);
        watch(100, nb, nl);
        chk("ign_busy_left", 32'(nb), 32'd2);
        chk("ign_done", {31'd0, bus.done}, 32'd1);
        request(1'b1, 15'h0000, 15'h0600, 15'd1, 16'h1234);
        chk("b2b_busy", {31'd0, bus.busy},  32'd1);
        chk("b2b_ld",   {31'd0, bus.mem_ld}, 32'd1);
        chk("b2b_addr", 32'(bus.mem_addr),  32'h0600);
        watch(100, nb, nl);
        chk("b2b_busy_cycles", 32'(nb), 32'd1);
        step();
        chk("ign_d0",  32'(mem[15'h0400]), 32'hA5A5);
        chk("ign_d1",  32'(mem[15'h0401]), 32'h5A5A);
        chk("ign_x0",  32'(mem[15'h0500]), 32'h5555);
        chk("ign_x1",  32'(mem[15'h0501]), 32'h5555);
        chk("b2b_m",   32'(mem[15'h0600]), 32'h1234);

        // ---- Reset during the WRITE of word 2 of 4
        for (int k = 0; k < 4; k++) begin
            preload(15'h0700 + 15'(k), 16'h00A0 + 16'(k));
            preload(15'h0800 + 15'(k), 16'hFFFF);
        end
        request(1'b0, 15'h0700, 15'h0800, 15'd4, 16'h0000);
        for (int k = 0; k < 5; k++) step();
        chk("rmid_ld_before",   {31'd0, bus.mem_ld}, 32'd1);
        chk("rmid_addr_before", 32'(bus.mem_addr),   32'h0802);
        #2;
        rst = 1'b1;
        #1;
        chk("rmid_ld",   {31'd0, bus.mem_ld}, 32'd0);
        chk("rmid_busy", {31'd0, bus.busy},   32'd0);
        chk("rmid_done", {31'd0, bus.done},   32'd0);
        chk("rmid_addr", 32'(bus.mem_addr),   32'h0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("rmid_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("rmid_idle_done", {31'd0, bus.done}, 32'd0);
        chk("rmid_m0", 32'(mem[15'h0800]), 32'h00A0);
        chk("rmid_m1", 32'(mem[15'h0801]), 32'h00A1);
        chk("rmid_m2", 32'(mem[15'h0802]), 32'hFFFF);
        chk("rmid_m3", 32'(mem[15'h0803]), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case a wait above ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stalled, want completion");
        $fatal(1, "timeout");
    end

endmodule
